// File: rtl/rrp_otf_convert_pkg.sv
// rrp_otf_convert_pkg: shared digit sizing and FSM states for the signed-digit converter.
// Signed digits are packed LSD-first: digit i lives at [i*D +: D].
package rrp_otf_convert_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction

endpackage

// File: rtl/rrp_otf_convert_step.sv
// rrp_otf_convert_step: one MSD-first on-the-fly conversion step on the Q/QM pair.
module rrp_otf_convert_step
  import rrp_otf_convert_pkg::*;
#(
  parameter int RADIX = 8,
  parameter int OUT_W = 19,
  localparam int K = $clog2(RADIX),
  localparam int D = digit_bits(RADIX)
) (
  input  logic [OUT_W-1:0]    q_cur,
  input  logic [OUT_W-1:0]    qm_cur,
  input  logic signed [D-1:0] digit,
  output logic [OUT_W-1:0]    q_nx,
  output logic [OUT_W-1:0]    qm_nx
);

  logic [K-1:0]     dm1;
  logic [OUT_W-1:0] q_hi, qm_hi;

  // With RADIX = 2^K, r+q and r-1+q reduce to the low K bits of q and q-1.
  assign dm1   = digit[K-1:0] - 1'b1;
  assign q_hi  = (digit[D-1] ? qm_cur : q_cur) << K;
  assign qm_hi = (digit > 0 ? q_cur : qm_cur) << K;
  assign q_nx  = q_hi | OUT_W'(digit[K-1:0]);
  assign qm_nx = qm_hi | OUT_W'(dm1);

endmodule

// File: rtl/rrp_otf_convert.sv
// rrp_otf_convert: converts a redundant signed-digit sum to two's complement, one digit per cycle.
module rrp_otf_convert
  import rrp_otf_convert_pkg::*;
#(
  parameter int RADIX = 8,
  parameter int WIDTH = 5,
  localparam int K = $clog2(RADIX),
  localparam int D = digit_bits(RADIX),
  localparam int NDIG = WIDTH + 1,
  localparam int OUT_W = K * NDIG + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NDIG*D-1:0] s_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = $clog2(NDIG + 1);

  state_t              state, state_nx;
  logic [NDIG*D-1:0]   sr;
  logic [OUT_W-1:0]    q_r, qm_r, q_nx, qm_nx;
  logic [CW-1:0]       cnt;
  logic                err;
  logic signed [D-1:0] msd, digit;
  logic                bad, last;

  assign msd       = sr[NDIG*D-1 -: D];
  assign bad       = msd == D'(-RADIX);
  assign digit     = bad ? '0 : msd;
  assign last      = cnt == CW'(NDIG - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;

  rrp_otf_convert_step #(.RADIX(RADIX), .OUT_W(OUT_W)) u_step (
    .q_cur (q_r),
    .qm_cur(qm_r),
    .digit (digit),
    .q_nx  (q_nx),
    .qm_nx (qm_nx)
  );

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? CONV : IDLE) :
               state == CONV ? (last ? DONE : CONV) :
                               (out_ready ? IDLE : DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      q_r      <= '0;
      qm_r     <= '1;
      cnt      <= '0;
      err      <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        sr   <= s_in;
        q_r  <= '0;
        qm_r <= '1;
        cnt  <= '0;
        err  <= 1'b0;
      end else if (state == CONV) begin
        sr   <= sr << D;
        q_r  <= q_nx;
        qm_r <= qm_nx;
        cnt  <= cnt + 1'b1;
        err  <= err | bad;
        if (last) begin
          out_data <= q_nx;
          out_err  <= err | bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_rrp_otf_convert.sv
// tb_rrp_otf_convert: scoreboard bench comparing converted results against an arithmetic digit-sum model.
module tb_rrp_otf_convert;

  localparam int D = 4;
  localparam int NDIG = 6;
  localparam int OUT_W = 19;

  logic              clock = 0;
  logic              reset = 1;
  logic [NDIG*D-1:0] s_in = '0;
  logic              in_valid = 0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_err;
  logic              out_valid;
  logic              out_ready = 0;

  int checks = 0;
  int errors = 0;
  logic [OUT_W:0] exp_q[$];

  rrp_otf_convert #(.RADIX(8), .WIDTH(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_in     (s_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [NDIG*D-1:0] pack(input int d5, d4, d3, d2, d1, d0);
    return {4'(d5), 4'(d4), 4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  // Expected {err, value}: plain weighted sum, illegal -8 digits counted as zero.
  function automatic logic [OUT_W:0] model(input logic [NDIG*D-1:0] s);
    longint v = 0;
    logic e = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      logic signed [D-1:0] d;
      d = s[i*D +: D];
      if (d == -4'sd8) e = 1;
      v = v * 8 + ((d == -4'sd8) ? 0 : longint'(d));
    end
    return {e, OUT_W'(v)};
  endfunction

  task automatic send(input logic [NDIG*D-1:0] s);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clock); #1; t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready in_ready=%0b required=1", in_ready);
    end else begin
      s_in = s;
      in_valid = 1;
      exp_q.push_back(model(s));
      @(posedge clock); #1;
      in_valid = 0;
    end
  endtask

  task automatic receive(input int exp_lat);
    int t = 1;
    logic [OUT_W:0] e;
    while (!out_valid && t < 30) begin
      @(posedge clock); #1; t++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout out_valid=%0b required=1", out_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (t !== exp_lat) begin
        errors++;
        $display("FAIL latency got=%0d required=%0d", t, exp_lat);
      end
    end
    e = exp_q.pop_front();
    if (out_data !== e[OUT_W-1:0]) begin
      errors++;
      $display("FAIL out_data got=%h required=%h", out_data, e[OUT_W-1:0]);
    end
    checks++;
    if (out_err !== e[OUT_W]) begin
      errors++;
      $display("FAIL out_err got=%0b required=%0b", out_err, e[OUT_W]);
    end
    out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    checks++;
    if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 19'h0}) begin
      errors++;
      $display("FAIL reset_state rdy=%0b vld=%0b err=%0b data=%h required 1/0/0/0",
               in_ready, out_valid, out_err, out_data);
    end
  endtask

  task automatic test_zero();
    send('0);
    receive(7);
  endtask

  task automatic test_values();
    logic [NDIG*D-1:0] ops[6];
    ops[0] = pack(0, 0, 0, 0, 1, -1);
    ops[1] = pack(0, 0, 0, 0, 0, -1);
    ops[2] = pack(7, 7, 7, 7, 7, 7);
    ops[3] = pack(-7, -7, -7, -7, -7, -7);
    ops[4] = pack(0, 0, -8, 0, 0, 0);
    ops[5] = pack(3, -5, 0, 2, -1, 6);
    for (int i = 0; i < 6; i++) begin
      send(ops[i]);
      receive(7);
    end
  endtask

  task automatic test_stall();
    logic [OUT_W:0] e;
    int t = 0;
    send(pack(1, -2, 3, -4, 5, -6));
    while (!out_valid && t < 30) begin
      @(posedge clock); #1; t++;
    end
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e[OUT_W-1:0]) begin
        errors++;
        $display("FAIL stall_hold vld=%0b rdy=%0b data=%h required 1/0/%h",
                 out_valid, in_ready, out_data, e[OUT_W-1:0]);
      end
      s_in = pack(7, 0, 0, 0, 0, 7);
      in_valid = (i % 2 == 0);
      @(posedge clock); #1;
      in_valid = 0;
    end
    receive(0);
    send(pack(-1, 2, -3, 4, -5, 6));
    receive(7);
  endtask

  task automatic test_reset_mid();
    send(pack(2, 2, 2, 2, 2, 2));
    void'(exp_q.pop_back());
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid rdy=%0b vld=%0b required 1/0", in_ready, out_valid);
    end
    repeat (8) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_output out_valid=%0b required=0", out_valid);
      end
    end
    send(pack(0, 5, -6, 1, 0, -3));
    receive(7);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_stall();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
